// File: rtl/mips_pkg.sv
// Shared fetch-unit types and constants.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_HOLD  = 2'd0,
      PC_INC   = 2'd1,
      PC_REDIR = 2'd2
   } pc_sel_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INC_BYTES = 32'd4;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC mux: hold, sequential +4 from the issued PC, or aligned redirect.
module pc_next
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_pc_i,
   input  logic [31:0] target_i,
   input  pc_sel_e     sel_i,
   output logic [31:0] pc_o
);

   always_comb begin
      pc_o = pc_i;
      unique case (sel_i)
         PC_INC:   pc_o = inst_pc_i + PC_INC_BYTES;
         PC_REDIR: pc_o = target_i & ~32'h0000_0003;
         default:  pc_o = pc_i;
      endcase
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: FETCH/ISSUE/HALT FSM with a single held instruction.
module inst_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_accept,
   output logic [31:0] inst_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        halt_in,
   output logic        halted
);

   fetch_state_e state_q, state_d;
   pc_sel_e      pc_sel;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_pc_q;
   logic         req_q, req_d;
   logic         load_inst;

   pc_next u_pc_next (
      .pc_i      (pc_q),
      .inst_pc_i (inst_pc_q),
      .target_i  (redirect_target),
      .sel_i     (pc_sel),
      .pc_o      (pc_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_b) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // req_q low in FETCH marks a dead cycle (after reset or a redirect); ready is ignored then.
   always_comb begin
      state_d   = state_q;
      pc_sel    = PC_HOLD;
      req_d     = req_q;
      load_inst = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (redirect) begin
               pc_sel = PC_REDIR;
               req_d  = 1'b0;
            end else begin
               req_d = 1'b1;
               if (req_q && imem_ready) begin
                  load_inst = 1'b1;
                  state_d   = ISSUE;
                  req_d     = 1'b0;
               end
            end
         end
         ISSUE: begin
            if (inst_accept && halt_in) begin
               state_d = HALT;
               req_d   = 1'b0;
            end else if (redirect) begin
               pc_sel  = PC_REDIR;
               state_d = FETCH;
               req_d   = 1'b1;
            end else if (inst_accept) begin
               pc_sel  = PC_INC;
               state_d = FETCH;
               req_d   = 1'b1;
            end
         end
         HALT: begin
            req_d = 1'b0;
         end
         default: begin
            state_d = FETCH;
            req_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      imem_req   = req_q;
      imem_addr  = pc_q;
      inst       = inst_q;
      inst_pc    = inst_pc_q;
      inst_valid = (state_q == ISSUE);
      halted     = (state_q == HALT);
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         req_q     <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         req_q <= req_d;
         if (load_inst) begin
            inst_q    <= imem_rdata;
            inst_pc_q <= pc_q;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
module tb_inst_fetch;

   logic        clk;
   logic        rst_b;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_accept;
   logic [31:0] inst_pc;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        halt_in;
   logic        halted;

   int total;
   int bad;

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .inst            (inst),
      .inst_valid      (inst_valid),
      .inst_accept     (inst_accept),
      .inst_pc         (inst_pc),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .halt_in         (halt_in),
      .halted          (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hAAAA_AAAA;
      tick();
      tick();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
      total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", inst); end
      total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h want=0", inst_pc); end
      rst_b = 1'b1;
      imem_ready = 1'b0;
      tick();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL post_rst_req got=%b want=1", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL post_rst_addr got=%h want=0", imem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_addr;
      logic [31:0] exp_inst;
      for (int i = 0; i < 3; i++) begin
         exp_addr = 32'(i) * 32'd4;
         exp_inst = 32'h1111_0000 + 32'(i);
         total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr || inst_valid !== 1'b0) begin
            bad++; $display("FAIL stream_fetch[%0d] got req=%b addr=%h valid=%b want req=1 addr=%h valid=0", i, imem_req, imem_addr, inst_valid, exp_addr);
         end
         imem_ready = 1'b1;
         imem_rdata = exp_inst;
         inst_accept = 1'b1;
         tick();
         imem_ready = 1'b0;
         total++; if (inst_valid !== 1'b1 || inst !== exp_inst || inst_pc !== exp_addr || imem_req !== 1'b0) begin
            bad++; $display("FAIL stream_issue[%0d] got valid=%b inst=%h pc=%h req=%b want valid=1 inst=%h pc=%h req=0", i, inst_valid, inst, inst_pc, imem_req, exp_inst, exp_addr);
         end
         tick();
      end
      inst_accept = 1'b0;
      total++; if (imem_addr !== 32'h0000_000C || imem_req !== 1'b1) begin bad++; $display("FAIL stream_next got addr=%h req=%b want addr=0000000c req=1", imem_addr, imem_req); end
   endtask

   task automatic test_wait();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_000C || inst_valid !== 1'b0) begin
            bad++; $display("FAIL wait[%0d] got req=%b addr=%h valid=%b want req=1 addr=0000000c valid=0", i, imem_req, imem_addr, inst_valid);
         end
      end
      imem_ready = 1'b1;
      imem_rdata = 32'h3333_3333;
      tick();
      imem_ready = 1'b0;
      total++; if (inst_valid !== 1'b1 || inst !== 32'h3333_3333 || inst_pc !== 32'h0000_000C) begin
         bad++; $display("FAIL wait_issue got valid=%b inst=%h pc=%h want valid=1 inst=33333333 pc=0000000c", inst_valid, inst, inst_pc);
      end
      tick();
      total++; if (inst_valid !== 1'b1 || inst !== 32'h3333_3333 || imem_req !== 1'b0) begin
         bad++; $display("FAIL issue_hold got valid=%b inst=%h req=%b want valid=1 inst=33333333 req=0", inst_valid, inst, imem_req);
      end
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      total++; if (imem_addr !== 32'h0000_0010 || inst_valid !== 1'b0) begin bad++; $display("FAIL wait_next got addr=%h valid=%b want addr=00000010 valid=0", imem_addr, inst_valid); end
   endtask

   task automatic test_redirect_issue();
      imem_ready = 1'b1;
      imem_rdata = 32'h4444_4444;
      tick();
      imem_ready = 1'b0;
      redirect = 1'b1;
      redirect_target = 32'h0000_0102;
      tick();
      redirect = 1'b0;
      total++; if (imem_addr !== 32'h0000_0100 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
         bad++; $display("FAIL redir_issue got addr=%h valid=%b req=%b want addr=00000100 valid=0 req=1", imem_addr, inst_valid, imem_req);
      end
      imem_ready = 1'b1;
      imem_rdata = 32'h5555_5555;
      tick();
      imem_ready = 1'b0;
      total++; if (inst_valid !== 1'b1 || inst !== 32'h5555_5555 || inst_pc !== 32'h0000_0100) begin
         bad++; $display("FAIL redir_refetch got valid=%b inst=%h pc=%h want valid=1 inst=55555555 pc=00000100", inst_valid, inst, inst_pc);
      end
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      total++; if (imem_addr !== 32'h0000_0104) begin bad++; $display("FAIL redir_seq got addr=%h want addr=00000104", imem_addr); end
   endtask

   task automatic test_redirect_ready();
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      redirect = 1'b1;
      redirect_target = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0000_0200) begin
         bad++; $display("FAIL redir_ready_drop got req=%b valid=%b addr=%h want req=0 valid=0 addr=00000200", imem_req, inst_valid, imem_addr);
      end
      tick();
      total++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h0000_0200) begin
         bad++; $display("FAIL redir_ready_rereq got req=%b valid=%b addr=%h want req=1 valid=0 addr=00000200", imem_req, inst_valid, imem_addr);
      end
      imem_rdata = 32'h6666_6666;
      tick();
      imem_ready = 1'b0;
      total++; if (inst_valid !== 1'b1 || inst !== 32'h6666_6666 || inst_pc !== 32'h0000_0200) begin
         bad++; $display("FAIL redir_ready_issue got valid=%b inst=%h pc=%h want valid=1 inst=66666666 pc=00000200", inst_valid, inst, inst_pc);
      end
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
   endtask

   task automatic test_wrap();
      redirect = 1'b1;
      redirect_target = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      total++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b0) begin bad++; $display("FAIL wrap_align got addr=%h req=%b want addr=fffffffc req=0", imem_addr, imem_req); end
      tick();
      imem_ready = 1'b1;
      imem_rdata = 32'h7777_7777;
      tick();
      imem_ready = 1'b0;
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_issue got valid=%b pc=%h want valid=1 pc=fffffffc", inst_valid, inst_pc); end
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      total++; if (imem_addr !== 32'h0000_0000 || imem_req !== 1'b1) begin bad++; $display("FAIL wrap_next got addr=%h req=%b want addr=00000000 req=1", imem_addr, imem_req); end
   endtask

   task automatic test_accept_idle();
      inst_accept = 1'b1;
      halt_in = 1'b1;
      tick();
      inst_accept = 1'b0;
      halt_in = 1'b0;
      total++; if (halted !== 1'b0 || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         bad++; $display("FAIL accept_idle got halted=%b valid=%b req=%b addr=%h want halted=0 valid=0 req=1 addr=00000000", halted, inst_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_halt();
      imem_ready = 1'b1;
      imem_rdata = 32'h8888_8888;
      tick();
      imem_ready = 1'b0;
      halt_in = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h0000_0300;
      inst_accept = 1'b1;
      tick();
      halt_in = 1'b0;
      total++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         bad++; $display("FAIL halt_enter got halted=%b req=%b valid=%b want halted=1 req=0 valid=0", halted, imem_req, inst_valid);
      end
      redirect_target = 32'h0000_0400;
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr === 32'h0000_0400) begin
            bad++; $display("FAIL halt_hold[%0d] got halted=%b req=%b valid=%b addr=%h want halted=1 req=0 valid=0 addr!=00000400", i, halted, imem_req, inst_valid, imem_addr);
         end
      end
      redirect = 1'b0;
      inst_accept = 1'b0;
   endtask

   task automatic test_reset_from_halt();
      imem_ready = 1'b1;
      imem_rdata = 32'h9999_9999;
      rst_b = 1'b0;
      tick();
      total++; if (halted !== 1'b0 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0) begin
         bad++; $display("FAIL halt_rst got halted=%b req=%b valid=%b inst=%h want halted=0 req=0 valid=0 inst=00000000", halted, imem_req, inst_valid, inst);
      end
      rst_b = 1'b1;
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
         bad++; $display("FAIL halt_rst_release got req=%b addr=%h valid=%b want req=1 addr=00000000 valid=0", imem_req, imem_addr, inst_valid);
      end
      tick();
      imem_ready = 1'b0;
      total++; if (inst_valid !== 1'b1 || inst !== 32'h9999_9999 || inst_pc !== 32'h0) begin
         bad++; $display("FAIL halt_rst_fetch got valid=%b inst=%h pc=%h want valid=1 inst=99999999 pc=00000000", inst_valid, inst, inst_pc);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_b = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = '0;
      inst_accept = 1'b0;
      redirect = 1'b0;
      redirect_target = '0;
      halt_in = 1'b0;
      test_reset();
      test_stream();
      test_wait();
      test_redirect_issue();
      test_redirect_ready();
      test_wrap();
      test_accept_idle();
      test_halt();
      test_reset_from_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
